// File: rtl/tl45_decode_hs.sv
// tl45_decode_hs: decode stage for the tl45 core with valid/ready handshakes
// on the fetch side (i_valid/o_ready) and on the execute side (o_valid/i_ready).
//
// Parameters
//   XLEN                width of PC, immediate and the PC-relative adder (>= 20)
//   LOAD_USE_INTERLOCK  1: hold back an instruction that reads the register an
//                       LW in the output slot writes, giving exactly one bubble
//
// Ports
//   i_clk, i_reset_n         clock (rising edge), asynchronous active-low reset
//   i_flush                  synchronous flush: clears the output slot, blocks input
//   i_valid/o_ready          fetch handshake, with i_pc and i_inst
//   o_valid/i_ready          downstream handshake
//   o_pc, o_opcode, o_skp_mode, o_dr, o_sr1, o_sr2, o_imm, o_illegal
//                            registered decoded fields
//
// Optional build macro TL45_DECODE_PERF_EN adds i_perf_clr and o_bubble_cnt, a
// saturating count of cycles in which a presented instruction was interlocked.
module tl45_decode_hs #(
    parameter int unsigned XLEN               = 32,
    parameter bit          LOAD_USE_INTERLOCK = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [3:0]      o_opcode,
    output logic            o_skp_mode,
    output logic [3:0]      o_dr,
    output logic [3:0]      o_sr1,
    output logic [3:0]      o_sr2,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
`ifdef TL45_DECODE_PERF_EN
    ,
    input  logic            i_perf_clr,
    output logic [31:0]     o_bubble_cnt
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_NAND = 4'h1,
        OP_ADDI = 4'h2,
        OP_LW   = 4'h3,
        OP_SW   = 4'h4,
        OP_GOTO = 4'h5,
        OP_JALR = 4'h6,
        OP_HALT = 4'h7,
        OP_SKP  = 4'h8,
        OP_LEA  = 4'h9,
        OP_ILL  = 4'hF
    } opcode_e;

    // Decoded (combinational) view of the presented instruction
    opcode_e         w_opcode;
    logic            w_skp;
    logic [3:0]      w_dr;
    logic [3:0]      w_sr1;
    logic [3:0]      w_sr2;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_rel;
    logic            w_hazard;
    logic            w_load;

    // Output slot
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    opcode_e         r_opcode;
    logic            r_skp;
    logic [3:0]      r_dr;
    logic [3:0]      r_sr1;
    logic [3:0]      r_sr2;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    assign w_sext = XLEN'($signed(i_inst[19:0]));
    assign w_rel  = w_sext + i_pc + XLEN'(1);

    always_comb begin
        w_opcode  = OP_ILL;
        w_skp     = 1'b0;
        w_dr      = '0;
        w_sr1     = '0;
        w_sr2     = '0;
        w_imm     = '0;
        w_illegal = 1'b0;
        case (i_inst[31:28])
            OP_ADD, OP_NAND: begin
                w_opcode = opcode_e'(i_inst[31:28]);
                w_dr     = i_inst[27:24];
                w_sr1    = i_inst[23:20];
                w_sr2    = i_inst[3:0];
            end
            OP_ADDI, OP_LW: begin
                w_opcode = opcode_e'(i_inst[31:28]);
                w_dr     = i_inst[27:24];
                w_sr1    = i_inst[23:20];
                w_imm    = w_sext;
            end
            OP_SW: begin
                w_opcode = OP_SW;
                w_sr1    = i_inst[23:20];
                w_sr2    = i_inst[27:24];
                w_imm    = w_sext;
            end
            OP_GOTO: begin
                w_opcode = OP_GOTO;
                w_imm    = w_rel;
            end
            OP_JALR: begin
                w_opcode = OP_JALR;
                w_dr     = i_inst[27:24];
                w_sr1    = i_inst[23:20];
            end
            OP_HALT: begin
                // HALT is issued as a jump to itself
                w_opcode = OP_GOTO;
                w_imm    = i_pc;
            end
            OP_SKP: begin
                w_opcode = OP_SKP;
                w_sr1    = i_inst[23:20];
                w_sr2    = i_inst[3:0];
            end
            OP_LEA: begin
                w_opcode = OP_LEA;
                w_dr     = i_inst[27:24];
                w_imm    = w_rel;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (!w_illegal) begin
            w_skp = i_inst[24];
        end
    end

    // Source fields are zero unless the opcode reads them, and r_dr is
    // non-zero here, so comparing the decoded sources covers exactly the
    // registers the instruction actually reads.
    assign w_hazard = LOAD_USE_INTERLOCK && r_valid && (r_opcode == OP_LW) &&
                      (r_dr != 4'd0) && ((w_sr1 == r_dr) || (w_sr2 == r_dr));

    assign o_ready = (!r_valid || i_ready) && !w_hazard && !i_flush;
    assign w_load  = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_opcode  <= OP_ILL;
            r_skp     <= 1'b0;
            r_dr      <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_opcode  <= OP_ILL;
            r_skp     <= 1'b0;
            r_dr      <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_pc      <= i_pc;
            r_opcode  <= w_opcode;
            r_skp     <= w_skp;
            r_dr      <= w_dr;
            r_sr1     <= w_sr1;
            r_sr2     <= w_sr2;
            r_imm     <= w_imm;
            r_illegal <= w_illegal;
        end else if (r_valid && i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_opcode   = r_opcode;
    assign o_skp_mode = r_skp;
    assign o_dr       = r_dr;
    assign o_sr1      = r_sr1;
    assign o_sr2      = r_sr2;
    assign o_imm      = r_imm;
    assign o_illegal  = r_illegal;

`ifdef TL45_DECODE_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bubble_cnt <= '0;
        end else if (i_perf_clr) begin
            r_bubble_cnt <= '0;
        end else if (i_valid && w_hazard && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_tl45_decode_hs.sv
module tb_tl45_decode_hs;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  op;
        logic        skp;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm;
        logic        ill;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ivalid = 1'b0;
    logic        iready = 1'b0;
    logic [31:0] ipc = '0;
    logic [31:0] iinst = '0;

    // DUT 0: interlock enabled, DUT 1: interlock disabled; same stimulus
    logic        rdy0, val0, skp0, ill0, rdy1, val1, skp1, ill1;
    logic [31:0] pc0, imm0, pc1, imm1;
    logic [3:0]  op0, dr0, s10, s20, op1, dr1, s11, s21;

    tl45_decode_hs #(.XLEN(32), .LOAD_USE_INTERLOCK(1'b1)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(ivalid),
        .o_ready(rdy0), .i_pc(ipc), .i_inst(iinst), .o_valid(val0),
        .i_ready(iready), .o_pc(pc0), .o_opcode(op0), .o_skp_mode(skp0),
        .o_dr(dr0), .o_sr1(s10), .o_sr2(s20), .o_imm(imm0), .o_illegal(ill0)
    );

    tl45_decode_hs #(.XLEN(32), .LOAD_USE_INTERLOCK(1'b0)) u_dut_ni (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(ivalid),
        .o_ready(rdy1), .i_pc(ipc), .i_inst(iinst), .o_valid(val1),
        .i_ready(iready), .o_pc(pc1), .o_opcode(op1), .o_skp_mode(skp1),
        .o_dr(dr1), .o_sr1(s11), .o_sr2(s21), .o_imm(imm1), .o_illegal(ill1)
    );

    out_t act [2];
    assign act[0] = {val0, pc0, op0, skp0, dr0, s10, s20, imm0, ill0};
    assign act[1] = {val1, pc1, op1, skp1, dr1, s11, s21, imm1, ill1};
    logic rdy [2];
    assign rdy[0] = rdy0;
    assign rdy[1] = rdy1;

    always #5 clk = ~clk;

    int  total = 0;
    int  bad = 0;
    bit  done = 1'b0;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, a, e, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic out_t reset_val();
        out_t r;
        r = '0;
        r.op = 4'hF;
        return r;
    endfunction

    function automatic out_t decode(input logic [31:0] inst, input logic [31:0] pc);
        out_t d;
        int unsigned op;
        logic [31:0] s;
        d = '0;
        d.valid = 1'b1;
        d.pc = pc;
        op = inst[31:28];
        s = {{12{inst[19]}}, inst[19:0]};
        d.op = inst[31:28];
        d.skp = inst[24];
        case (op)
            0, 1:    begin d.dr = inst[27:24]; d.sr1 = inst[23:20]; d.sr2 = inst[3:0]; end
            2, 3:    begin d.dr = inst[27:24]; d.sr1 = inst[23:20]; d.imm = s; end
            4:       begin d.sr1 = inst[23:20]; d.sr2 = inst[27:24]; d.imm = s; end
            5:       d.imm = s + pc + 32'd1;
            6:       begin d.dr = inst[27:24]; d.sr1 = inst[23:20]; end
            7:       begin d.op = 4'h5; d.imm = pc; end
            8:       begin d.sr1 = inst[23:20]; d.sr2 = inst[3:0]; end
            9:       begin d.dr = inst[27:24]; d.imm = s + pc + 32'd1; end
            default: begin d = '0; d.valid = 1'b1; d.pc = pc; d.op = 4'hF; d.ill = 1'b1; end
        endcase
        return d;
    endfunction

    function automatic bit reads(input logic [31:0] inst, input logic [3:0] r);
        int unsigned op;
        bit use1, use2;
        logic [3:0] src2;
        op = inst[31:28];
        use1 = (op inside {0, 1, 2, 3, 4, 6, 8});
        use2 = (op inside {0, 1, 4, 8});
        src2 = (op == 4) ? inst[27:24] : inst[3:0];
        return (r != 4'd0) && ((use1 && inst[23:20] == r) || (use2 && src2 == r));
    endfunction

    out_t m  [2];
    out_t nx [2];

    function automatic bit exp_ready(input int k);
        bit hz;
        hz = (k == 0) && m[k].valid && (m[k].op == 4'h3) && reads(iinst, m[k].dr);
        return (!m[k].valid || iready) && !hz && !flush;
    endfunction

    // Compare process: inputs change only at negedge, so check 2 time units later
    initial begin
        m[0] = reset_val();
        m[1] = reset_val();
        while (!done) begin
            @(negedge clk);
            #2;
            if (done) break;
            for (int k = 0; k < 2; k++) begin
                bit er;
                if (!rst_n) m[k] = reset_val();
                chk($sformatf("model_out%0d", k), act[k], m[k]);
                er = exp_ready(k);
                chk($sformatf("model_ready%0d", k), rdy[k], er);
                nx[k] = m[k];
                if (!rst_n || flush) nx[k] = reset_val();
                else if (ivalid && er) nx[k] = decode(iinst, ipc);
                else if (m[k].valid && iready) nx[k].valid = 1'b0;
            end
            @(posedge clk);
            m[0] = nx[0];
            m[1] = nx[1];
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rn, input bit v, input bit r, input bit f,
                         input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clk);
        rst_n = rn; ivalid = v; iready = r; flush = f; ipc = pc; iinst = inst;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    localparam logic [31:0] LW3  = 32'h3310_0000;  // LW r3, r1, 0
    localparam logic [31:0] ADD5 = 32'h0530_0002;  // ADD r5, r3, r2
    localparam logic [31:0] LW0  = 32'h3010_0000;  // LW r0, r1, 0
    localparam logic [31:0] ADD0 = 32'h0500_0002;  // ADD r5, r0, r2

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_valid", val0, 1'b0);
        chk("rst_opcode", op0, 4'hF);
        chk("rst_fields", {pc0, dr0, s10, s20, imm0, ill0, skp0}, '0);

        // ADD r1, r2, r4 at pc 0x10
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0123_0004);
        idle();
        chk("add_valid", val0, 1'b1);
        chk("add_fields", {op0, dr0, s10, s20}, 16'h0124);
        chk("add_imm_pc", {imm0, pc0}, {32'h0, 32'h10});

        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h500F_FFFE);  // GOTO -2
        idle();
        chk("goto_imm", imm0, 32'h0000_00FF);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h9000_0001);  // LEA +1
        idle();
        chk("lea_wrap_imm", imm0, 32'h1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h7000_0000);  // HALT
        idle();
        chk("halt_op_imm", {op0, imm0}, {4'h5, 32'h40});
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'hC123_4567);  // illegal
        idle();
        chk("illegal", {ill0, op0, dr0, s10, s20, imm0}, {1'b1, 4'hF, 12'h0, 32'h0});

        // Load-use: one bubble with interlock, none without
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, LW3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h204, ADD5);
        chk("lu_lw_out", {val0, op0}, {1'b1, 4'h3});
        chk("lu_ready_il", rdy0, 1'b0);
        chk("lu_ready_noil", rdy1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h204, ADD5);
        chk("lu_bubble", {val0, rdy0}, 2'b01);
        chk("lu_noil_add", {val1, op1, dr1}, {1'b1, 4'h0, 4'h5});
        idle();
        chk("lu_add_after", {val0, op0, dr0, pc0}, {1'b1, 4'h0, 4'h5, 32'h204});

        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h210, LW0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h214, ADD0);
        chk("lw_r0_ready", rdy0, 1'b1);
        idle();
        chk("lw_r0_nobubble", {val0, op0, pc0}, {1'b1, 4'h0, 32'h214});

        // Downstream stall for 3 cycles, then release
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0123_0004);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h1456_0007);
            chk("stall_hold", {val0, pc0, rdy0}, {1'b1, 32'h300, 1'b0});
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h304, 32'h1456_0007);
        chk("stall_release_ready", rdy0, 1'b1);
        idle();
        chk("stall_next", {val0, op0, pc0}, {1'b1, 4'h1, 32'h304});

        // Flush with o_valid=1 and i_valid=1
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0123_0004);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h404, 32'h1456_0007);
        chk("flush_ready", {val0, rdy0}, 2'b10);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("flush_out", {val0, op0, pc0}, {1'b0, 4'hF, 32'h0});

        // Asynchronous reset in the middle of a transfer
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0123_0004);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h504, 32'h0123_0004);
        chk("async_rst", {val0, op0, pc0}, {1'b0, 4'hF, 32'h0});
        idle();

        // Randomised traffic, small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] op;
            logic [31:0] inst;
            op = ($urandom_range(0, 2) == 0) ? 4'h3 : 4'($urandom_range(0, 15));
            inst = {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom),
                    16'($urandom), 2'b00, 2'($urandom)};
            drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                  $urandom, inst);
        end

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
